ps2_key_decoder: RTL

Converts the raw PS/2 scan-code byte stream (set 2) from the PS/2 receiver into complete key events with make/break and extended flags, buffering them in a small FIFO with a valid/ready handshake. It also holds the code of the most recently pressed, still-held key as a steady 8-bit value for the VGA picture generator. It sits between the PS/2 receiver and the VGA picture generator / any event consumer, in the system clock domain.

---
 rtl/ps2_key_decoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ============================================================================
// ps2_key_decoder: PS/2 set-2 byte stream to key events, with event FIFO and
// held-key register. Optional: PS2_KEY_DECODER_ASCII_EN adds evt_ascii.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_key_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] key_data,
`ifdef PS2_KEY_DECODER_ASCII_EN
  output logic [7:0] evt_ascii,
`endif
  output logic       overflow
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_skip;
  logic [c_TW-1:0]   r_tcnt;
  logic              w_timeout;
  logic              w_prefix;
  logic              w_ignore;
  logic              w_emit;
  logic              w_ext;
  logic              w_brk;

  logic [7:0]        r_mem_code [FIFO_DEPTH];
  logic              r_mem_ext  [FIFO_DEPTH];
  logic              r_mem_brk  [FIFO_DEPTH];
  logic [c_PW-1:0]   r_wr;
  logic [c_PW-1:0]   r_rd;
  logic [c_PW:0]     r_cnt;
  logic              r_ovf;
  logic [7:0]        r_key;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  assign w_timeout = (r_tcnt == c_TW'(TIMEOUT_CYC));
  assign w_prefix  = (byte_in == 8'hE0) || (byte_in == 8'hF0);
  assign w_ignore  = (byte_in == 8'hAA) || (byte_in == 8'hFA) || (byte_in == 8'hFE) ||
                     (byte_in == 8'hEE) || (byte_in == 8'h00) || (byte_in == 8'hFF) ||
                     (byte_in == 8'hE1);

  always_comb begin
    w_emit = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (byte_valid) begin
      case (r_state)
        S_IDLE:    w_emit = !w_prefix && !w_ignore;
        S_EXT:     begin w_emit = !w_prefix; w_ext = 1'b1; end
        S_BRK:     begin w_emit = !w_prefix; w_brk = 1'b1; end
        S_EXT_BRK: begin w_emit = !w_prefix; w_ext = 1'b1; w_brk = 1'b1; end
        default:   w_emit = 1'b0;
      endcase
    end
  end

  // A byte on the timeout edge wins: it is decoded in the pre-timeout state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
      r_tcnt  <= '0;
    end else begin
      if (byte_valid || w_timeout) r_tcnt <= '0;
      else if (r_state != S_IDLE)  r_tcnt <= r_tcnt + 1'b1;

      if (byte_valid) begin
        case (r_state)
          S_IDLE: begin
            if (byte_in == 8'hE0)      r_state <= S_EXT;
            else if (byte_in == 8'hF0) r_state <= S_BRK;
            else if (byte_in == 8'hE1) begin
              r_skip  <= 3'd7;
              r_state <= S_SKIP;
            end
          end
          S_EXT: begin
            if (byte_in == 8'hF0)      r_state <= S_EXT_BRK;
            else if (byte_in != 8'hE0) r_state <= S_IDLE;
          end
          S_SKIP: begin
            r_skip <= r_skip - 3'd1;
            if (r_skip <= 3'd1) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_timeout) begin
        r_state <= S_IDLE;
        r_skip  <= 3'd0;
      end
    end
  end

`ifdef PS2_KEY_DECODER_ASCII_EN
  logic [7:0] r_mem_ascii [FIFO_DEPTH];
  logic [7:0] w_ascii;

  function automatic logic [7:0] f_ascii(input logic [7:0] c);
    case (c)
      8'h1C: f_ascii = "A"; 8'h32: f_ascii = "B"; 8'h21: f_ascii = "C"; 8'h23: f_ascii = "D";
      8'h24: f_ascii = "E"; 8'h2B: f_ascii = "F"; 8'h34: f_ascii = "G"; 8'h33: f_ascii = "H";
      8'h43: f_ascii = "I"; 8'h3B: f_ascii = "J"; 8'h42: f_ascii = "K"; 8'h4B: f_ascii = "L";
      8'h3A: f_ascii = "M"; 8'h31: f_ascii = "N"; 8'h44: f_ascii = "O"; 8'h4D: f_ascii = "P";
      8'h15: f_ascii = "Q"; 8'h2D: f_ascii = "R"; 8'h1B: f_ascii = "S"; 8'h2C: f_ascii = "T";
      8'h3C: f_ascii = "U"; 8'h2A: f_ascii = "V"; 8'h1D: f_ascii = "W"; 8'h22: f_ascii = "X";
      8'h35: f_ascii = "Y"; 8'h1A: f_ascii = "Z";
      8'h45: f_ascii = "0"; 8'h16: f_ascii = "1"; 8'h1E: f_ascii = "2"; 8'h26: f_ascii = "3";
      8'h25: f_ascii = "4"; 8'h2E: f_ascii = "5"; 8'h36: f_ascii = "6"; 8'h3D: f_ascii = "7";
      8'h3E: f_ascii = "8"; 8'h46: f_ascii = "9";
      8'h29: f_ascii = 8'h20;
      8'h5A: f_ascii = 8'h0D;
      default: f_ascii = 8'h00;
    endcase
  endfunction

  assign w_ascii   = w_ext ? 8'h00 : f_ascii(byte_in);
  assign evt_ascii = r_mem_ascii[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem_ascii[i] <= 8'h00;
    end else if (w_push) begin
      r_mem_ascii[r_wr] <= w_ascii;
    end
  end
`endif

  assign w_full = (r_cnt == (c_PW + 1)'(FIFO_DEPTH));
  assign w_pop  = (r_cnt != '0) && evt_ready;
  assign w_push = w_emit && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_code[i] <= 8'h00;
        r_mem_ext[i]  <= 1'b0;
        r_mem_brk[i]  <= 1'b0;
      end
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_key <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem_code[r_wr] <= byte_in;
        r_mem_ext[r_wr]  <= w_ext;
        r_mem_brk[r_wr]  <= w_brk;
        r_wr             <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      r_ovf <= w_emit && !w_push;
      // Held-key tracking follows every decoded event, dropped or not.
      if (w_emit && !w_ext) begin
        if (!w_brk)                r_key <= byte_in;
        else if (byte_in == r_key) r_key <= 8'h00;
      end
    end
  end

  assign evt_code  = r_mem_code[r_rd];
  assign evt_ext   = r_mem_ext[r_rd];
  assign evt_break = r_mem_brk[r_rd];
  assign evt_valid = (r_cnt != '0);
  assign key_data  = r_key;
  assign overflow  = r_ovf;

endmodule

`default_nettype wire
